// File: rtl/mmio_map_pkg.sv
// Shared address-map constants for the data-memory / MMIO bridge:
// register offsets, STATUS bit positions and the read-path region select.
package mmio_map_pkg;

  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_SW     = 3'd1;
  localparam logic [2:0] OFF_TIMER  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_TXDATA = 3'd5;
  localparam logic [2:0] OFF_TXCNT  = 3'd6;

  localparam int STAT_MATCH = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic {
    SEL_MMIO = 1'b0,
    SEL_RAM  = 1'b1
  } sel_e;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte transmit FIFO with sticky overflow; a push while full is only
// accepted when a pop frees a slot in the same cycle.
module mmio_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [7:0]             data_i,
  input  logic                   pop_i,
  input  logic                   clrOvf_i,
  output logic [7:0]             head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          popOk, pushOk, pushDrop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign popOk      = pop_i && !empty_o;
  assign pushOk     = push_i && (!full_o || popOk);
  assign pushDrop   = push_i && full_o && !popOk;
  assign head_o     = mem_q[rdPtr_q];
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + PW'(1);
      if (popOk)  rdPtr_q <= rdPtr_q + PW'(1);
      case ({pushOk, popOk})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A new overflow in the same cycle as a clear must stay visible.
      if (pushDrop)      ovf_q <= 1'b1;
      else if (clrOvf_i) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && pushOk) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Routes processor data-memory accesses to external RAM or to the MMIO
// register set, keeping the one-edge read timing of a plain dmem.
module dmem_mmio_bridge
  import mmio_map_pkg::*;
#(
  parameter int          RAM_ADDR_W = 12,
  parameter logic [31:0] MMIO_BASE  = 32'h0000F000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          LED_W      = 8,
  parameter int          SW_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           address_dmem,
  input  logic [31:0]           data,
  input  logic                  wren,
  output logic [31:0]           q_dmem,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_data,
  output logic                  ram_wren,
  input  logic [31:0]           ram_q,
  output logic [LED_W-1:0]      leds,
  input  logic [SW_W-1:0]       switches,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  timer_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        isRam, isMmio;
  logic [31:0] offset;
  logic [2:0]  regOff;
  logic        wrLed, wrTimer, wrCmp, wrStatus, wrTx;

  sel_e             sel_q;
  logic [31:0]      rdData_q, rdData_d;
  logic [LED_W-1:0] leds_q;
  logic [SW_W-1:0]  sw1_q, sw2_q;
  logic [31:0]      timer_q, cmp_q;
  logic             match_q, matchSet;

  logic          fifoFull, fifoEmpty, fifoOvf;
  logic [CW-1:0] fifoCount;

  // RAM wins any overlap; MMIO decodes an 8-word window above MMIO_BASE.
  assign isRam    = ((address_dmem >> RAM_ADDR_W) == 32'd0);
  assign offset   = address_dmem - MMIO_BASE;
  assign isMmio   = !isRam && (address_dmem >= MMIO_BASE) && (offset < 32'd8);
  assign regOff   = offset[2:0];

  assign wrLed    = wren && isMmio && (regOff == OFF_LED);
  assign wrTimer  = wren && isMmio && (regOff == OFF_TIMER);
  assign wrCmp    = wren && isMmio && (regOff == OFF_CMP);
  assign wrStatus = wren && isMmio && (regOff == OFF_STATUS);
  assign wrTx     = wren && isMmio && (regOff == OFF_TXDATA);

  assign ram_addr = address_dmem[RAM_ADDR_W-1:0];
  assign ram_data = data;
  assign ram_wren = wren && isRam;

  assign matchSet = (timer_q == cmp_q);

  always_comb begin
    rdData_d = 32'd0;
    if (isMmio) begin
      case (regOff)
        OFF_LED:    rdData_d = 32'(leds_q);
        OFF_SW:     rdData_d = 32'(sw2_q);
        OFF_TIMER:  rdData_d = timer_q;
        OFF_CMP:    rdData_d = cmp_q;
        OFF_STATUS: rdData_d = 32'({fifoOvf, fifoEmpty, fifoFull, match_q});
        OFF_TXCNT:  rdData_d = 32'(fifoCount);
        default:    rdData_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q    <= SEL_MMIO;
      rdData_q <= 32'd0;
      leds_q   <= '0;
      sw1_q    <= '0;
      sw2_q    <= '0;
      timer_q  <= 32'd0;
      cmp_q    <= 32'hFFFFFFFF;
      match_q  <= 1'b0;
    end else begin
      sel_q    <= isRam ? SEL_RAM : SEL_MMIO;
      rdData_q <= rdData_d;
      sw1_q    <= switches;
      sw2_q    <= sw1_q;
      if (wrLed) leds_q <= data[LED_W-1:0];
      timer_q  <= wrTimer ? 32'd0 : timer_q + 32'd1;
      if (wrCmp) cmp_q <= data;
      if (matchSet)                          match_q <= 1'b1;
      else if (wrStatus && data[STAT_MATCH]) match_q <= 1'b0;
    end
  end

  assign q_dmem    = (sel_q == SEL_RAM) ? ram_q : rdData_q;
  assign leds      = leds_q;
  assign timer_irq = match_q;
  assign tx_valid  = !fifoEmpty;

  mmio_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_txFifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (wrTx),
    .data_i     (data[7:0]),
    .pop_i      (tx_valid && tx_ready),
    .clrOvf_i   (wrStatus && data[STAT_OVF]),
    .head_o     (tx_data),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount),
    .overflow_o (fifoOvf)
  );

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge with a behavioural synchronous RAM
// attached to the ram_* ports.
module tb_dmem_mmio_bridge;

  localparam logic [31:0] BASE     = 32'h0000F000;
  localparam logic [31:0] A_LED    = BASE + 32'd0;
  localparam logic [31:0] A_SW     = BASE + 32'd1;
  localparam logic [31:0] A_TIMER  = BASE + 32'd2;
  localparam logic [31:0] A_CMP    = BASE + 32'd3;
  localparam logic [31:0] A_STATUS = BASE + 32'd4;
  localparam logic [31:0] A_TXDATA = BASE + 32'd5;
  localparam logic [31:0] A_TXCNT  = BASE + 32'd6;
  localparam logic [31:0] A_UNMAP  = BASE + 32'd7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = 32'd0;
  logic [31:0] data = 32'd0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic [7:0]  leds;
  logic [7:0]  switches = 8'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        timer_irq;

  int testsRun = 0;
  int testsFailed = 0;
  int ramWrenPulses = 0;
  logic [31:0] rd;
  logic [31:0] ramMem [4096];

  dmem_mmio_bridge dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q),
    .leds         (leds),
    .switches     (switches),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .timer_irq    (timer_irq)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wren) begin
      ramMem[ram_addr] <= ram_data;
      ramWrenPulses <= ramWrenPulses + 1;
    end
    ram_q <= ramMem[ram_addr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [31:0] d);
    address_dmem = a;
    data = d;
    wren = 1'b1;
    tick();
    wren = 1'b0;
    address_dmem = 32'd0;
    data = 32'd0;
  endtask

  task automatic doRead(input logic [31:0] a, output logic [31:0] v);
    address_dmem = a;
    wren = 1'b0;
    tick();
    v = q_dmem;
    address_dmem = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    testsRun++; if (q_dmem !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_q got %h expected %h", q_dmem, 32'd0); end
    testsRun++; if (leds !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_leds got %h expected %h", leds, 8'd0); end
    testsRun++; if (tx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_txvalid got %b expected 0", tx_valid); end
    testsRun++; if (timer_irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_irq got %b expected 0", timer_irq); end
    doRead(A_TIMER, rd);
    testsRun++; if (rd !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_timer got %h expected %h", rd, 32'd0); end
    doRead(A_CMP, rd);
    testsRun++; if (rd !== 32'hFFFFFFFF) begin testsFailed++; $display("[TB] FAIL reset_cmp got %h expected %h", rd, 32'hFFFFFFFF); end
    doRead(A_STATUS, rd);
    testsRun++; if (rd !== 32'h4) begin testsFailed++; $display("[TB] FAIL reset_status got %h expected %h", rd, 32'h4); end
    doRead(A_TXCNT, rd);
    testsRun++; if (rd !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_txcount got %h expected %h", rd, 32'd0); end
  endtask

  task automatic test_ram();
    address_dmem = 32'd5;
    data = 32'hDEADBEEF;
    wren = 1'b1;
    #1;
    testsRun++; if (ram_wren !== 1'b1) begin testsFailed++; $display("[TB] FAIL ram_wren got %b expected 1", ram_wren); end
    tick();
    wren = 1'b0;
    address_dmem = 32'd0;
    doRead(32'd5, rd);
    testsRun++; if (rd !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL ram_load got %h expected %h", rd, 32'hDEADBEEF); end
    testsRun++; if (ramWrenPulses !== 1) begin testsFailed++; $display("[TB] FAIL ram_pulses got %0d expected 1", ramWrenPulses); end
    testsRun++; if (leds !== 8'd0 || tx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL ram_side_effect got leds=%h txv=%b expected leds=00 txv=0", leds, tx_valid); end
    doWrite(32'd0, 32'h12345678);
    address_dmem = 32'h00001000;
    data = 32'h0;
    wren = 1'b1;
    #1;
    testsRun++; if (ram_wren !== 1'b0) begin testsFailed++; $display("[TB] FAIL ram_edge_wren got %b expected 0", ram_wren); end
    tick();
    wren = 1'b0;
    doRead(32'h00001000, rd);
    testsRun++; if (rd !== 32'd0) begin testsFailed++; $display("[TB] FAIL ram_edge_read got %h expected %h", rd, 32'd0); end
    doRead(32'd0, rd);
    testsRun++; if (rd !== 32'h12345678) begin testsFailed++; $display("[TB] FAIL ram_word0 got %h expected %h", rd, 32'h12345678); end
  endtask

  task automatic test_led_unmapped();
    address_dmem = A_LED;
    data = 32'h1A5;
    wren = 1'b1;
    #1;
    testsRun++; if (ram_wren !== 1'b0) begin testsFailed++; $display("[TB] FAIL led_ramwren got %b expected 0", ram_wren); end
    tick();
    wren = 1'b0;
    testsRun++; if (leds !== 8'hA5) begin testsFailed++; $display("[TB] FAIL led_value got %h expected %h", leds, 8'hA5); end
    doWrite(A_UNMAP, 32'hFFFFFFFF);
    testsRun++; if (leds !== 8'hA5 || tx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL unmapped_write got leds=%h txv=%b expected leds=a5 txv=0", leds, tx_valid); end
    doRead(A_UNMAP, rd);
    testsRun++; if (rd !== 32'd0) begin testsFailed++; $display("[TB] FAIL unmapped_read got %h expected %h", rd, 32'd0); end
    doRead(A_LED, rd);
    testsRun++; if (rd !== 32'h000000A5) begin testsFailed++; $display("[TB] FAIL led_read got %h expected %h", rd, 32'h000000A5); end
    doRead(A_TXDATA, rd);
    testsRun++; if (rd !== 32'd0) begin testsFailed++; $display("[TB] FAIL txdata_read got %h expected %h", rd, 32'd0); end
  endtask

  task automatic test_timer();
    doWrite(A_TIMER, 32'd0);
    doWrite(A_CMP, 32'd10);
    for (int i = 0; i < 9; i++) tick();
    testsRun++; if (timer_irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL timer_early got %b expected 0", timer_irq); end
    tick();
    testsRun++; if (timer_irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL timer_match got %b expected 1", timer_irq); end
    doRead(A_STATUS, rd);
    testsRun++; if (rd !== 32'h5) begin testsFailed++; $display("[TB] FAIL timer_status got %h expected %h", rd, 32'h5); end
    doWrite(A_STATUS, 32'h1);
    testsRun++; if (timer_irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL timer_clear got %b expected 0", timer_irq); end
    doWrite(A_TIMER, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    testsRun++; if (timer_irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL timer_rearm got %b expected 0", timer_irq); end
    doWrite(A_STATUS, 32'h1);
    testsRun++; if (timer_irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL timer_set_wins got %b expected 1", timer_irq); end
    doWrite(A_STATUS, 32'h1);
    testsRun++; if (timer_irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL timer_clear2 got %b expected 0", timer_irq); end
  endtask

  task automatic test_switches();
    switches = 8'h5A;
    tick();
    tick();
    doRead(A_SW, rd);
    testsRun++; if (rd !== 32'h0000005A) begin testsFailed++; $display("[TB] FAIL sw_sync got %h expected %h", rd, 32'h5A); end
    switches = 8'hC3;
    doRead(A_SW, rd);
    testsRun++; if (rd !== 32'h0000005A) begin testsFailed++; $display("[TB] FAIL sw_delay got %h expected %h", rd, 32'h5A); end
  endtask

  task automatic test_fifo_fill();
    tx_ready = 1'b0;
    address_dmem = A_TXDATA;
    data = 32'h41;
    wren = 1'b1;
    #1;
    testsRun++; if (tx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL fifo_no_bypass got %b expected 0", tx_valid); end
    tick();
    wren = 1'b0;
    testsRun++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin testsFailed++; $display("[TB] FAIL fifo_first got txv=%b data=%h expected txv=1 data=41", tx_valid, tx_data); end
    for (int i = 1; i < 5; i++) doWrite(A_TXDATA, 32'h41 + 32'(i));
    doRead(A_TXCNT, rd);
    testsRun++; if (rd !== 32'd4) begin testsFailed++; $display("[TB] FAIL fifo_count got %h expected %h", rd, 32'd4); end
    doRead(A_STATUS, rd);
    testsRun++; if (rd !== 32'hA) begin testsFailed++; $display("[TB] FAIL fifo_full_ovf got %h expected %h", rd, 32'hA); end
    testsRun++; if (tx_data !== 8'h41) begin testsFailed++; $display("[TB] FAIL fifo_head got %h expected %h", tx_data, 8'h41); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      testsRun++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin testsFailed++; $display("[TB] FAIL fifo_drain got txv=%b data=%h expected txv=1 data=%h", tx_valid, tx_data, 8'(8'h41 + i)); end
      tick();
    end
    testsRun++; if (tx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL fifo_empty got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
    doWrite(A_STATUS, 32'h8);
    doRead(A_STATUS, rd);
    testsRun++; if (rd !== 32'h4) begin testsFailed++; $display("[TB] FAIL fifo_ovf_clear got %h expected %h", rd, 32'h4); end
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) doWrite(A_TXDATA, 32'h51 + 32'(i));
    doRead(A_STATUS, rd);
    testsRun++; if (rd !== 32'h2) begin testsFailed++; $display("[TB] FAIL b2b_full got %h expected %h", rd, 32'h2); end
    tx_ready = 1'b1;
    doWrite(A_TXDATA, 32'h55);
    tx_ready = 1'b0;
    testsRun++; if (tx_data !== 8'h52) begin testsFailed++; $display("[TB] FAIL b2b_head got %h expected %h", tx_data, 8'h52); end
    doRead(A_TXCNT, rd);
    testsRun++; if (rd !== 32'd4) begin testsFailed++; $display("[TB] FAIL b2b_count got %h expected %h", rd, 32'd4); end
    doRead(A_STATUS, rd);
    testsRun++; if (rd !== 32'h2) begin testsFailed++; $display("[TB] FAIL b2b_no_ovf got %h expected %h", rd, 32'h2); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      testsRun++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h52 + i)) begin testsFailed++; $display("[TB] FAIL b2b_drain got txv=%b data=%h expected txv=1 data=%h", tx_valid, tx_data, 8'(8'h52 + i)); end
      tick();
    end
    testsRun++; if (tx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_empty got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    doWrite(A_LED, 32'h3C);
    doWrite(A_CMP, 32'h1234);
    for (int i = 0; i < 3; i++) doWrite(A_TXDATA, 32'h61 + 32'(i));
    testsRun++; if (tx_valid !== 1'b1 || leds !== 8'h3C) begin testsFailed++; $display("[TB] FAIL mid_setup got txv=%b leds=%h expected txv=1 leds=3c", tx_valid, leds); end
    address_dmem = A_TXDATA;
    data = 32'h77;
    wren = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wren = 1'b0;
    address_dmem = 32'd0;
    testsRun++; if (tx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_txvalid got %b expected 0", tx_valid); end
    testsRun++; if (leds !== 8'd0) begin testsFailed++; $display("[TB] FAIL mid_leds got %h expected %h", leds, 8'd0); end
    testsRun++; if (q_dmem !== 32'd0) begin testsFailed++; $display("[TB] FAIL mid_q got %h expected %h", q_dmem, 32'd0); end
    doRead(A_CMP, rd);
    testsRun++; if (rd !== 32'hFFFFFFFF) begin testsFailed++; $display("[TB] FAIL mid_cmp got %h expected %h", rd, 32'hFFFFFFFF); end
    doRead(A_TXCNT, rd);
    testsRun++; if (rd !== 32'd0) begin testsFailed++; $display("[TB] FAIL mid_count got %h expected %h", rd, 32'd0); end
    doRead(A_STATUS, rd);
    testsRun++; if (rd !== 32'h4) begin testsFailed++; $display("[TB] FAIL mid_status got %h expected %h", rd, 32'h4); end
    testsRun++; if (tx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_push_dropped got %b expected 0", tx_valid); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led_unmapped();
    test_timer();
    test_switches();
    test_fifo_fill();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
